adder_result_accumulator: RTL

- Downstream stage of the 8-bit adder.
- Consumes each adder result through a valid/ready handshake and sums the results into a wide accumulator.
- Keeps a sample count and a sticky overflow flag.
- On a dump request, snapshots the accumulator and streams it out byte-serially, MSB first, over a second valid/ready handshake, so the wide total can leave through 8-bit pins.

---
 rtl/adder_result_accumulator_if.sv | 22 ++
 rtl/adder_result_accumulator.sv | 108 ++++++++++
 2 files changed

// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between the adder, the accumulator and the byte-serial sink.
// Holds the sample input channel and the byte output channel.
interface adder_result_accumulator_if #(
  parameter int IN_W = 8
);
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      out_byte;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_byte, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_byte, out_valid
  );
endinterface

// File: rtl/adder_result_accumulator.sv
// Sums adder results into a wide accumulator with sample count and sticky overflow,
// and streams a snapshot of the total out MSB byte first on request.
module adder_result_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16,
  parameter int SAT   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  adder_result_accumulator_if.slave    bus,
  input  logic                         clear,
  input  logic                         dump,
  output logic [7:0]                   count,
  output logic                         ovf,
  output logic                         busy
);
  localparam int NB    = ACC_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NB - 1);

  typedef enum logic {ACCUM, DUMP} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [ACC_W-1:0] shadow, shadow_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [7:0]       count_nx;
  logic             ovf_nx;
  logic [ACC_W:0]   ext;
  logic [ACC_W:0]   sum;
  logic             rdy;
  logic             take;

  // Top bit of the result is the carry out; under SAT the low bits clamp to all-ones.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W:0]   b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + b;
    if (SAT != 0 && s[ACC_W]) s[ACC_W-1:0] = '1;
    return s;
  endfunction

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    shadow_nx = shadow;
    idx_nx    = idx;
    count_nx  = count;
    ovf_nx    = ovf;
    ext       = '0;
    ext[IN_W-1:0] = bus.in_data;
    sum       = acc_add(acc, ext);
    rdy       = (state == ACCUM) && !clear;
    take      = bus.in_valid && rdy;

    bus.in_ready  = rdy;
    bus.out_valid = (state == DUMP);
    bus.out_byte  = (state == DUMP) ? shadow[{idx, 3'b000} +: 8] : 8'h00;
    busy          = (state == DUMP);

    if (take) begin
      acc_nx = sum[ACC_W-1:0];
      if (count != 8'hFF) count_nx = count + 8'd1;
      if (sum[ACC_W]) ovf_nx = 1'b1;
    end
    if (clear) begin
      acc_nx   = '0;
      count_nx = '0;
      ovf_nx   = 1'b0;
    end

    case (state)
      ACCUM: begin
        // Snapshot the post-edge total so a same-cycle sample is included.
        if (dump && !clear) begin
          shadow_nx = acc_nx;
          idx_nx    = IDX_TOP;
          state_nx  = DUMP;
        end
      end
      DUMP: begin
        if (bus.out_ready) begin
          if (idx == '0) state_nx = ACCUM;
          else           idx_nx   = idx - 1'b1;
        end
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ACCUM;
      acc    <= '0;
      shadow <= '0;
      idx    <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      shadow <= shadow_nx;
      idx    <= idx_nx;
      count  <= count_nx;
      ovf    <= ovf_nx;
    end
  end
endmodule
